// File: rtl/endme_pkg.sv
// endme_pkg: shared loader defaults and state encoding.
package endme_pkg;
  localparam int INSTR_W_DEF = 9;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, DONE, ERR} ld_state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader writing instruction memory, then releasing the processor.
module prog_loader import endme_pkg::*; #(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 256
) (
  input  logic               CLK,
  input  logic               reset_ctrl,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               proc_reset,
  output logic               load_done,
  output logic               load_err
);
  ld_state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic [15:0] len_q, len_d, len_full;
  logic [7:0] lo_q, lo_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, xfer, last;
  assign in_ready = state_q inside {LEN_LO, LEN_HI, INS_LO, INS_HI};
  assign xfer = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};
  assign last = 17'(cnt_q) + 17'd1 == {1'b0, len_q};
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign proc_reset = state_q != DONE;
  assign load_done = state_q == DONE;
  assign load_err = state_q == ERR;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    lo_d = lo_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE, DONE, ERR: if (load_start) begin
        state_d = LEN_LO;
        cnt_d = '0;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = in_data;
        state_d = LEN_HI;
      end
      LEN_HI: if (xfer) begin
        len_d = len_full;
        state_d = len_full == 16'd0 ? DONE : {1'b0, len_full} > 17'(DEPTH) ? ERR : INS_LO;
      end
      INS_LO: if (xfer) begin
        lo_d = in_data;
        state_d = INS_HI;
      end
      INS_HI: if (xfer) begin
        if (|in_data[7:1]) state_d = ERR;
        else begin
          wr_en_d = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = INSTR_W'({in_data[0], lo_q});
          cnt_d = cnt_q + 1'b1;
          state_d = last ? DONE : INS_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      lo_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      lo_q <= lo_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized byte streams checked against a stream-level loader model.
module tb_prog_loader;
  logic CLK = 1'b0;
  logic reset_ctrl, load_start, in_valid, in_ready, wr_en, proc_reset, load_done, load_err;
  logic [7:0] in_data;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  int total = 0, bad = 0;
  logic [7:0] s[$];
  int exp_wr[$], obs_wr[$];
  int exp_st, n_cons;
  logic [16:0] prev_wr;
  bit seen = 0;

  prog_loader dut (
    .CLK(CLK), .reset_ctrl(reset_ctrl), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .proc_reset(proc_reset), .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  always begin
    @(posedge CLK);
    #1;
    if (wr_en) obs_wr.push_back(int'({wr_addr, wr_data}));
    else if (seen && !reset_ctrl) chk("stable", int'({wr_addr, wr_data}), int'(prev_wr));
    prev_wr = {wr_addr, wr_data};
    seen = 1;
  end

  // expected status: 0 idle, 1 done, 2 error
  task automatic model();
    int len, lo, hi;
    exp_wr.delete();
    len = int'(s[0]) + 256 * int'(s[1]);
    n_cons = 2;
    exp_st = 1;
    if (len > 256) exp_st = 2;
    else for (int i = 0; i < len; i++) begin
      lo = int'(s[n_cons]);
      hi = int'(s[n_cons + 1]);
      n_cons += 2;
      if (hi > 1) begin
        exp_st = 2;
        break;
      end
      exp_wr.push_back(i * 512 + hi * 256 + lo);
    end
  endtask

  task automatic check_end(input string tag, input int st);
    chk({tag, "_done"}, int'(load_done), int'(st == 1));
    chk({tag, "_err"}, int'(load_err), int'(st == 2));
    chk({tag, "_preset"}, int'(proc_reset), int'(st != 1));
    chk({tag, "_rdy"}, int'(in_ready), 0);
  endtask

  task automatic run_load(input string tag, input int stall);
    int k;
    model();
    obs_wr.delete();
    @(negedge CLK);
    load_start = 1;
    in_valid = 0;
    @(negedge CLK);
    load_start = 0;
    for (int i = 0; i < n_cons; i++) begin
      k = stall < 0 ? int'($urandom_range(0, 3)) : stall;
      repeat (k) begin
        in_valid = 0;
        in_data = 8'($urandom);
        load_start = $urandom_range(0, 7) == 0;
        chk({tag, "_rdy_stall"}, int'(in_ready), 1);
        @(negedge CLK);
      end
      in_valid = 1;
      in_data = s[i];
      load_start = $urandom_range(0, 7) == 0;
      chk({tag, "_rdy"}, int'(in_ready), 1);
      @(negedge CLK);
    end
    in_valid = 0;
    load_start = 0;
    repeat (3) @(negedge CLK);
    chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) chk({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    check_end(tag, exp_st);
  endtask

  task automatic rand_stream();
    int r, len;
    r = $urandom_range(0, 12);
    len = r == 0 ? 0 : r == 1 ? int'($urandom_range(257, 65535)) : r == 2 ? 256 : int'($urandom_range(1, 6));
    s.delete();
    s.push_back(8'(len));
    s.push_back(8'(len >> 8));
    for (int i = 0; i < len && i < 256; i++) begin
      s.push_back(8'($urandom));
      s.push_back($urandom_range(0, 19) == 0 ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset_ctrl = 1;
    load_start = 0;
    in_valid = 0;
    in_data = 0;
    repeat (2) @(negedge CLK);
    chk("rst_rdy", int'(in_ready), 0);
    chk("rst_wren", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_preset", int'(proc_reset), 1);
    chk("rst_done", int'(load_done), 0);
    chk("rst_err", int'(load_err), 0);
    reset_ctrl = 0;
    s = '{8'h03, 8'h00, 8'h12, 8'h00, 8'hFF, 8'h01, 8'h05, 8'h00};
    run_load("three", 0);
    chk("three_w2", obs_wr.size() > 2 ? obs_wr[2] : -1, 2 * 512 + 9'h005);
    s = '{8'h00, 8'h00};
    run_load("zero", 0);
    s = '{8'h01, 8'h01};
    run_load("toolong", 0);
    s = '{8'h02, 8'h00, 8'h34, 8'h02};
    run_load("badhi", 0);
    s = '{8'h01, 8'h00, 8'h77, 8'h01};
    run_load("recover", 0);
    chk("recover_w0", obs_wr.size() > 0 ? obs_wr[0] : -1, 9'h177);
    s = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h5A, 8'h00};
    run_load("stall", 5);
    s = '{8'h00, 8'h01};
    run_load("full", -1);
    for (int n = 0; n < 40; n++) begin
      rand_stream();
      run_load("rnd", -1);
    end
    obs_wr.delete();
    s = '{8'h04, 8'h00, 8'hAA};
    @(negedge CLK);
    load_start = 1;
    @(negedge CLK);
    load_start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = s[i];
      @(negedge CLK);
    end
    reset_ctrl = 1;
    in_valid = 1;
    in_data = 8'h01;
    @(negedge CLK);
    reset_ctrl = 0;
    in_valid = 0;
    repeat (3) @(negedge CLK);
    chk("midrst_nwr", obs_wr.size(), 0);
    chk("midrst_wren", int'(wr_en), 0);
    check_end("midrst", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter INSTR_W, default 9, instruction word width.
REQ-002 Parameter ADDR_W, default 8, instruction memory address width.
REQ-003 Parameter DEPTH, default 256, max program length in words (DEPTH <= 2**ADDR_W).
REQ-004 Port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset_ctrl  input  1  synchronous, active-high reset.
REQ-006 Port load_start  input  1  one-cycle request to begin a program load.
REQ-007 Port in_valid  input  1  host byte valid.
REQ-008 Port in_data  input  8  host byte.
REQ-009 Port in_ready  output  1  loader accepts byte this cycle.
REQ-010 Port wr_en  output  1  instruction memory write strobe.
REQ-011 Port wr_addr  output  ADDR_W  instruction memory write address.
REQ-012 Port wr_data  output  INSTR_W  instruction word to write.
REQ-013 Port proc_reset  output  1  holds processor (PC) in reset while high.
REQ-014 Port load_done  output  1  level; program loaded, processor released.
REQ-015 Port load_err  output  1  level; load aborted on protocol error.

Function
REQ-016 Byte transfer occurs exactly on cycles where in_valid and in_ready are both high; in_data ignored otherwise.
REQ-017 States: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, DONE, ERR.
REQ-018 in_ready high only in LEN_LO, LEN_HI, INS_LO, INS_HI; low elsewhere, combinational from state only.
REQ-019 IDLE, DONE or ERR with load_start high -> LEN_LO next cycle; clears word counter, load_done, load_err.
REQ-020 load_start in LEN_LO..INS_HI ignored.
REQ-021 LEN_LO transfer: latch length[7:0] -> LEN_HI; LEN_HI transfer: latch length[15:8].
REQ-022 On LEN_HI transfer: length==0 -> DONE; length>DEPTH -> ERR; else -> INS_LO.
REQ-023 INS_LO transfer: latch wr_data[7:0] -> INS_HI.
REQ-024 INS_HI transfer: bit0 -> instruction bit 8; bits 7:1 nonzero -> ERR with no write.
REQ-025 Valid INS_HI transfer: wr_en high for exactly the next cycle, wr_addr = word counter, wr_data = assembled word, all registered.
REQ-026 Word counter starts at 0, increments by 1 per write; after write of word length-1 -> DONE in same cycle as that wr_en pulse; otherwise -> INS_LO.
REQ-027 wr_addr never wraps; length<=DEPTH guarantees last address DEPTH-1.
REQ-028 wr_en, wr_addr, wr_data stable and wr_en low in every cycle other than REQ-025 pulses.
REQ-029 proc_reset high in all states except DONE; falls on the cycle DONE is entered.
REQ-030 load_done high exactly while in DONE; load_err high exactly while in ERR.
REQ-031 Host may stall (in_valid low) any number of cycles in any receiving state; state held.

Reset
REQ-032 reset_ctrl high at a clock edge: state IDLE, counter 0, length 0, wr_en 0, wr_addr 0, wr_data 0, proc_reset 1, load_done 0, load_err 0.
REQ-033 reset_ctrl dominates load_start and any transfer on the same edge; reset mid-load aborts with no further writes.

Structure
REQ-034 Shared package endme_pkg holds INSTR_W, ADDR_W defaults and the loader state enum typedef.
REQ-035 Single module, no sub-modules; one state register, one counter, one length register, registered write outputs.

Verification
REQ-036 Length 3, bytes {03,00, 12,00, FF,01, 05,00} -> writes addr0=012, addr1=1FF, addr2=005; DONE; proc_reset 1->0 after third write.
REQ-037 Length bytes {00,00} -> DONE next cycle, no wr_en, load_done 1.
REQ-038 Length 0x0101 with DEPTH=256 -> ERR, load_err 1, no wr_en, proc_reset stays 1.
REQ-039 Length 2, first word high byte 0x02 -> ERR, zero writes; then load_start + valid 1-word stream -> DONE, addr0 written.
REQ-040 Length 2 with in_valid low 5 cycles between every byte -> identical writes to unstalled run, in_ready held high.
REQ-041 reset_ctrl pulse after first INS_LO byte of length-4 load -> IDLE, no write, proc_reset 1, load_done 0.
